decode_writeback_stage: RTL
===========================

// Module: decode_writeback_stage
// PURPOSE
//  Pipeline stage directly downstream of fetch. Holds the D pipeline register, which
//  captures the fetch outputs under stall/bubble control. Owns the 15-entry register file;
//  the write-back stage writes into it. Decodes register ids, forwards operands from
//  E/M/W, and drives valA/valB/srcA/srcB/dstE/dstM to the E register.
// PARAMETERS
//  DATA_W   64   datapath width of valC/valP/register values
//  NREG     15   architectural registers, ids 0..14; id 4'hF = RNONE
// PORTS
//  clk        in   1       rising-edge clock
//  rst_n      in   1       synchronous, active-low reset
//  D_stall    in   1       hold D register
//  D_bubble   in   1       load nop into D register
//  f_stat     in   4       fetch status (1 ADR, 2 INS, 3 HLT, 4 AOK)
//  f_icode    in   4       fetched icode
//  f_ifun     in   4       fetched ifun
//  f_rA,f_rB  in   4 ea    fetched register ids
//  f_valC     in   DATA_W  fetched constant
//  f_valP     in   DATA_W  incremented PC
//  e_dstE     in   4       execute dest id;      e_valE in DATA_W execute ALU result
//  M_dstE     in   4       memory-stage dstE;    M_valE in DATA_W
//  M_dstM     in   4       memory-stage dstM;    m_valM in DATA_W memory read data
//  W_dstE     in   4       write-back dstE;      W_valE in DATA_W
//  W_dstM     in   4       write-back dstM;      W_valM in DATA_W
//  D_stat,D_icode,D_ifun  out 4 ea   D register contents
//  D_rA,D_rB              out 4 ea
//  D_valC,D_valP          out DATA_W
//  d_srcA,d_srcB          out 4      decoded source ids (to hazard unit and E)
//  d_dstE,d_dstM          out 4      decoded destination ids
//  d_valA,d_valB          out DATA_W forwarded operands
// BEHAVIOUR
//  D register (posedge clk), priority: !rst_n > D_stall > D_bubble > load.
//   - Reset and bubble both load a nop: stat=4, icode=1, ifun=0, rA=rB=F, valC=valP=0.
//   - Stall holds every D field. Stall and bubble together: stall wins.
//   - Otherwise all f_* inputs are captured. Latency: 1 cycle from f_* to D_*.
//  Register file (posedge clk):
//   - !rst_n clears all 15 registers to 0.
//   - Else if W_dstE!=F, write W_valE; if W_dstM!=F, write W_valM.
//   - Same id on both ports: W_valM wins (popq %rsp).
//   - Writes to id F are ignored. Reads are combinational.
//   - Write-then-read of the same register in one cycle is covered by W forwarding,
//     not by the register file.
//  Decode (combinational on D_*):
//   - srcA = D_rA for icode 2,4,6,A; 4 (RSP) for 9,B; else F.
//   - srcB = D_rB for icode 4,5,6; 4 for 8,9,A,B; else F.
//   - dstE = D_rB for icode 2,3,6; 4 for 8,9,A,B; else F.
//   - dstM = D_rA for icode 5,B; else F.
//  Forwarding, d_valA in priority order:
//   1. icode 7 or 8 -> D_valP.
//   2. srcA==e_dstE -> e_valE.
//   3. srcA==M_dstM -> m_valM.
//   4. srcA==M_dstE -> M_valE.
//   5. srcA==W_dstM -> W_valM.
//   6. srcA==W_dstE -> W_valE.
//   7. else rf[srcA].
//   - d_valB uses the same chain on srcB, without step 1.
//   - A source id of F never matches a forward; it yields 0.
//   - An icode outside 0..B decodes to all-F ids and 0 values; D_stat passes through.
// TESTING
//  - Reset: rst_n=0 one cycle -> D_icode=1, D_stat=4, every rf entry reads 0.
//  - Load/stall/bubble: f_icode=6,rA=3,rB=2 loads. Next cycle D_stall=1 with new f_* ->
//    D fields unchanged. Then D_bubble=1 -> D_icode=1, d_dstE=F.
//  - Forward priority: srcA=3 with e_dstE=3(e_valE=7), M_dstM=3(m_valM=9) -> d_valA=7.
//    Drop e_dstE -> 9.
//  - WB collision: W_dstE=W_dstM=4, W_valE=0x10, W_valM=0x20 -> rf[4]=0x20 next cycle.
//  - Call/jump: D_icode=8, D_valP=0x5A -> d_valA=0x5A, d_srcB=4, d_dstE=4.
//  - popq: D_icode=B, rA=2 -> d_srcA=4, d_srcB=4, d_dstE=4, d_dstM=2.

Source files
------------

// File: rtl/decode_writeback_stage.sv
// Decode / write-back stage: D pipeline register, 15-entry register file,
// source/destination decode and E/M/W operand forwarding.
module decode_writeback_stage #(
  parameter int DATA_W = 64,
  parameter int NREG   = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              D_stall,
  input  logic              D_bubble,
  input  logic [3:0]        f_stat,
  input  logic [3:0]        f_icode,
  input  logic [3:0]        f_ifun,
  input  logic [3:0]        f_rA,
  input  logic [3:0]        f_rB,
  input  logic [DATA_W-1:0] f_valC,
  input  logic [DATA_W-1:0] f_valP,
  input  logic [3:0]        e_dstE,
  input  logic [DATA_W-1:0] e_valE,
  input  logic [3:0]        M_dstE,
  input  logic [DATA_W-1:0] M_valE,
  input  logic [3:0]        M_dstM,
  input  logic [DATA_W-1:0] m_valM,
  input  logic [3:0]        W_dstE,
  input  logic [DATA_W-1:0] W_valE,
  input  logic [3:0]        W_dstM,
  input  logic [DATA_W-1:0] W_valM,
  output logic [3:0]        D_stat,
  output logic [3:0]        D_icode,
  output logic [3:0]        D_ifun,
  output logic [3:0]        D_rA,
  output logic [3:0]        D_rB,
  output logic [DATA_W-1:0] D_valC,
  output logic [DATA_W-1:0] D_valP,
  output logic [3:0]        d_srcA,
  output logic [3:0]        d_srcB,
  output logic [3:0]        d_dstE,
  output logic [3:0]        d_dstM,
  output logic [DATA_W-1:0] d_valA,
  output logic [DATA_W-1:0] d_valB
);

  typedef enum logic [3:0] {
    I_HALT   = 4'h0, I_NOP    = 4'h1, I_RRMOVQ = 4'h2, I_IRMOVQ = 4'h3,
    I_RMMOVQ = 4'h4, I_MRMOVQ = 4'h5, I_OPQ    = 4'h6, I_JXX    = 4'h7,
    I_CALL   = 4'h8, I_RET    = 4'h9, I_PUSHQ  = 4'hA, I_POPQ   = 4'hB
  } icode_e;

  localparam logic [3:0] RNONE    = 4'hF;
  localparam logic [3:0] RRSP     = 4'h4;
  localparam logic [3:0] STAT_AOK = 4'h4;

  logic [DATA_W-1:0] rf [NREG];
  logic [DATA_W-1:0] rf_a, rf_b;

  always_ff @(posedge clk) begin
    if (!rst_n || (D_bubble && !D_stall)) begin
      D_stat  <= STAT_AOK;
      D_icode <= I_NOP;
      D_ifun  <= '0;
      D_rA    <= RNONE;
      D_rB    <= RNONE;
      D_valC  <= '0;
      D_valP  <= '0;
    end else if (!D_stall) begin
      D_stat  <= f_stat;
      D_icode <= f_icode;
      D_ifun  <= f_ifun;
      D_rA    <= f_rA;
      D_rB    <= f_rB;
      D_valC  <= f_valC;
      D_valP  <= f_valP;
    end
  end

  // M port written last so it wins when both ports target the same id.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREG; i++) rf[i] <= '0;
    end else begin
      if (W_dstE != RNONE && int'(W_dstE) < NREG) rf[W_dstE] <= W_valE;
      if (W_dstM != RNONE && int'(W_dstM) < NREG) rf[W_dstM] <= W_valM;
    end
  end

  always_comb begin
    d_srcA = RNONE;
    d_srcB = RNONE;
    d_dstE = RNONE;
    d_dstM = RNONE;
    case (D_icode)
      I_RRMOVQ: begin d_srcA = D_rA; d_dstE = D_rB; end
      I_IRMOVQ: d_dstE = D_rB;
      I_RMMOVQ: begin d_srcA = D_rA; d_srcB = D_rB; end
      I_MRMOVQ: begin d_srcB = D_rB; d_dstM = D_rA; end
      I_OPQ:    begin d_srcA = D_rA; d_srcB = D_rB; d_dstE = D_rB; end
      I_CALL:   begin d_srcB = RRSP; d_dstE = RRSP; end
      I_RET:    begin d_srcA = RRSP; d_srcB = RRSP; d_dstE = RRSP; end
      I_PUSHQ:  begin d_srcA = D_rA; d_srcB = RRSP; d_dstE = RRSP; end
      I_POPQ:   begin d_srcA = RRSP; d_srcB = RRSP; d_dstE = RRSP; d_dstM = D_rA; end
      default:  ;
    endcase
  end

  assign rf_a = (int'(d_srcA) < NREG) ? rf[d_srcA] : '0;
  assign rf_b = (int'(d_srcB) < NREG) ? rf[d_srcB] : '0;

  always_comb begin
    d_valA = '0;
    if (D_icode == I_JXX || D_icode == I_CALL) d_valA = D_valP;
    else if (d_srcA == RNONE)                  d_valA = '0;
    else if (d_srcA == e_dstE)                 d_valA = e_valE;
    else if (d_srcA == M_dstM)                 d_valA = m_valM;
    else if (d_srcA == M_dstE)                 d_valA = M_valE;
    else if (d_srcA == W_dstM)                 d_valA = W_valM;
    else if (d_srcA == W_dstE)                 d_valA = W_valE;
    else                                       d_valA = rf_a;
  end

  always_comb begin
    d_valB = '0;
    if (d_srcB == RNONE)       d_valB = '0;
    else if (d_srcB == e_dstE) d_valB = e_valE;
    else if (d_srcB == M_dstM) d_valB = m_valM;
    else if (d_srcB == M_dstE) d_valB = M_valE;
    else if (d_srcB == W_dstM) d_valB = W_valM;
    else if (d_srcB == W_dstE) d_valB = W_valE;
    else                       d_valB = rf_b;
  end

endmodule
